// File: rtl/pci_memtarget_pkg.sv
// Shared PCI command codes, target state encoding and command decode helpers.
package pci_memtarget_pkg;

  localparam logic [3:0] PCI_CFGREAD   = 4'hA;
  localparam logic [3:0] PCI_CFGWRITE  = 4'hB;
  localparam logic [3:0] PCI_MEMREAD   = 4'h6;
  localparam logic [3:0] PCI_MEMWRITE  = 4'h7;
  localparam logic [3:0] PCI_MEMRDMULT = 4'hC;
  localparam logic [3:0] PCI_MEMRDLINE = 4'hE;
  localparam logic [3:0] PCI_MEMWRINV  = 4'hF;

  // Last word of the 4 KB window; a burst is disconnected on it.
  localparam logic [9:0] LAST_WORD = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_WAIT,
    ST_WR_REQ,
    ST_DATA,
    ST_STOP,
    ST_TURN
  } state_t;

  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return (cmd == PCI_MEMREAD) || (cmd == PCI_MEMRDMULT) || (cmd == PCI_MEMRDLINE) ||
           (cmd == PCI_MEMWRITE) || (cmd == PCI_MEMWRINV);
  endfunction

  function automatic logic is_write_cmd(input logic [3:0] cmd);
    return (cmd == PCI_MEMWRITE) || (cmd == PCI_MEMWRINV);
  endfunction

endpackage

// File: rtl/pci_memtarget_tmo_counter.sv
// Local-latency watchdog: counts edges spent waiting for an acknowledge and
// flags expiry on the edge that reaches TIMEOUT.
module pci_tmo_counter #(
  parameter int TIMEOUT = 16,
  parameter int TCW     = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [TCW-1:0] LAST = TCW'(TIMEOUT - 1);

  logic [TCW-1:0] cnt_q;
  logic [TCW-1:0] cnt_d;

  // Expiry is the edge whose count would reach TIMEOUT while still waiting.
  assign expire_o = run_i && (cnt_q == LAST);

  // Next count: clear on a new request, otherwise advance while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pci_memtarget.sv
// PCI memory-space target: claims memory cycles in the configured 4 KB window
// and bridges each data phase onto a local req/ack bus.
module pci_memtarget
  import pci_memtarget_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TCW     = 5
) (
  input  logic        pci_clk_i,
  input  logic        pci_rst_i,
  input  logic        pci_frame_ni,
  input  logic        pci_irdy_ni,
  output logic        pci_devsel_no,
  output logic        pci_trdy_no,
  output logic        pci_stop_no,
  input  logic [3:0]  pci_cbe_ni,
  input  logic [31:0] pci_ad_i,
  output logic [31:0] pci_ad_o,
  output logic        active_o,
  input  logic        memen_i,
  input  logic [19:0] addr_i,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [9:0]  mem_adr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i
);

  state_t      state_q, state_d;
  logic        devsel_q, devsel_d, trdy_q, trdy_d, stop_q, stop_d;
  logic        active_q, active_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] ad_q, ad_d, dat_q, dat_d;
  logic [9:0]  adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic        wr_q, wr_d, disc_q, disc_d, frame_prev_q;
  logic        last_word, hit, tmo_expire;

  // Address-phase decode: new FRAME# assertion, memory enabled, window and command match.
  assign hit = !pci_frame_ni && frame_prev_q && memen_i &&
               (pci_ad_i[31:12] == addr_i) && is_mem_cmd(pci_cbe_ni);

  // The current phase must end with STOP#: window end or an unaligned start.
  assign last_word = (adr_q == LAST_WORD) || disc_q;

  pci_tmo_counter #(.TIMEOUT(TIMEOUT), .TCW(TCW)) u_tmo (
    .clk_i    (pci_clk_i),
    .rst_i    (pci_rst_i),
    .clear_i  (stb_d && !stb_q),
    .run_i    (stb_q && !mem_ack_i),
    .expire_o (tmo_expire)
  );

  // Next-state and output decode for the target state machine.
  always_comb begin
    state_d  = state_q;
    devsel_d = devsel_q;
    trdy_d   = trdy_q;
    stop_d   = stop_q;
    active_d = active_q;
    ad_d     = ad_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    wr_d     = wr_q;
    disc_d   = disc_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          adr_d    = pci_ad_i[11:2];
          disc_d   = |pci_ad_i[1:0];
          wr_d     = is_write_cmd(pci_cbe_ni);
          devsel_d = 1'b0;
          if (is_write_cmd(pci_cbe_ni)) begin
            state_d = ST_WR_WAIT;
          end else begin
            state_d = ST_RD_REQ;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = 4'hF;
          end
        end
      end
      ST_RD_REQ: begin
        // Turnaround cycle after the address phase has passed; drive AD from now on.
        active_d = 1'b1;
        if (mem_ack_i) begin
          ad_d    = mem_dat_i;
          stb_d   = 1'b0;
          trdy_d  = 1'b0;
          stop_d  = !last_word;
          state_d = ST_DATA;
        end else if (tmo_expire) begin
          stb_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_WR_WAIT: begin
        if (!pci_irdy_ni) begin
          dat_d   = pci_ad_i;
          sel_d   = ~pci_cbe_ni;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (mem_ack_i) begin
          stb_d   = 1'b0;
          trdy_d  = 1'b0;
          stop_d  = !last_word;
          state_d = ST_DATA;
        end else if (tmo_expire) begin
          stb_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_DATA: begin
        if (!pci_irdy_ni) begin
          trdy_d = 1'b1;
          if (pci_frame_ni) begin
            state_d  = ST_TURN;
            devsel_d = 1'b1;
            stop_d   = 1'b1;
            active_d = 1'b0;
          end else if (!stop_q) begin
            state_d = ST_STOP;
          end else begin
            adr_d = adr_q + 1'b1;
            if (wr_q) begin
              state_d = ST_WR_WAIT;
            end else begin
              state_d = ST_RD_REQ;
              stb_d   = 1'b1;
              we_d    = 1'b0;
              sel_d   = 4'hF;
            end
          end
        end
      end
      ST_STOP: begin
        if (pci_frame_ni && pci_irdy_ni) begin
          state_d  = ST_TURN;
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
          stop_d   = 1'b1;
          active_d = 1'b0;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge pci_clk_i) begin
    if (pci_rst_i) begin
      state_q      <= ST_IDLE;
      devsel_q     <= 1'b1;
      trdy_q       <= 1'b1;
      stop_q       <= 1'b1;
      active_q     <= 1'b0;
      ad_q         <= '0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      wr_q         <= 1'b0;
      disc_q       <= 1'b0;
      frame_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      devsel_q     <= devsel_d;
      trdy_q       <= trdy_d;
      stop_q       <= stop_d;
      active_q     <= active_d;
      ad_q         <= ad_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      wr_q         <= wr_d;
      disc_q       <= disc_d;
      frame_prev_q <= pci_frame_ni;
    end
  end

  assign pci_devsel_no = devsel_q;
  assign pci_trdy_no   = trdy_q;
  assign pci_stop_no   = stop_q;
  assign pci_ad_o      = ad_q;
  assign active_o      = active_q;
  assign mem_stb_o     = stb_q;
  assign mem_we_o      = we_q;
  assign mem_adr_o     = adr_q;
  assign mem_sel_o     = sel_q;
  assign mem_dat_o     = dat_q;

endmodule

// File: tb/tb_pci_memtarget.sv
// Directed bench for pci_memtarget: stimulus queues expected local requests and
// PCI data-phase outcomes; a negedge monitor pops and compares them.
module tb_pci_memtarget;
  import pci_memtarget_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_n = 1'b1, irdy_n = 1'b1;
  logic        devsel_n, trdy_n, stop_n, active;
  logic [3:0]  cbe_n = 4'h0;
  logic [31:0] ad_in = '0, ad_out;
  logic        memen = 1'b0;
  logic [19:0] bar = '0;
  logic        stb, we;
  logic [9:0]  adr;
  logic [3:0]  sel;
  logic [31:0] wdat_o, rdat_i;
  logic        ack = 1'b0;

  pci_memtarget dut (
    .pci_clk_i(clk), .pci_rst_i(rst), .pci_frame_ni(frame_n), .pci_irdy_ni(irdy_n),
    .pci_devsel_no(devsel_n), .pci_trdy_no(trdy_n), .pci_stop_no(stop_n),
    .pci_cbe_ni(cbe_n), .pci_ad_i(ad_in), .pci_ad_o(ad_out), .active_o(active),
    .memen_i(memen), .addr_i(bar), .mem_stb_o(stb), .mem_we_o(we), .mem_adr_o(adr),
    .mem_sel_o(sel), .mem_dat_o(wdat_o), .mem_dat_i(rdat_i), .mem_ack_i(ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [9:0] adr; logic [3:0] sel; logic [31:0] dat; } loc_t;
  typedef struct { logic data; logic [31:0] rd; logic chk_rd; logic stop; int edges; } pci_t;

  loc_t loc_q[$];
  pci_t pci_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Local memory responder: ack after ack_dly waiting cycles; read data pattern or fixed.
  int          ack_dly = 0;
  int          wcnt = 0;
  logic        rd_pat = 1'b1;
  logic [31:0] rd_base = '0;
  assign rdat_i = rd_pat ? (32'hA5A50000 | {22'd0, adr}) : rd_base;

  always @(posedge clk) begin
    #1;
    if (stb && !ack) begin
      if (wcnt == ack_dly) ack = 1'b1;
      else wcnt++;
    end else begin
      ack  = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: local request on stb rising, PCI outcome on TRDY#/IRDY# or STOP# alone.
  logic stb_prev = 1'b0, stop_prev = 1'b1, devsel_seen = 1'b0;
  int   stb_edges = 0;
  loc_t le;
  pci_t pe;

  always @(negedge clk) begin
    if (!rst) begin
      if (stb && !stb_prev) begin
        stb_edges = 0;
        if (loc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL loc_unexpected: got request at adr %h we %b expected none", adr, we);
        end else begin
          le = loc_q.pop_front();
          chk("loc_we", 32'(we), 32'(le.we));
          chk("loc_adr", 32'(adr), 32'(le.adr));
          chk("loc_sel", 32'(sel), 32'(le.sel));
          if (le.we) chk("loc_dat", wdat_o, le.dat);
        end
      end
      if (stb) stb_edges++;
      if (!trdy_n && !irdy_n) begin
        if (pci_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pci_unexpected: got data phase expected none");
        end else begin
          pe = pci_q.pop_front();
          chk("pci_kind_data", 32'd1, 32'(pe.data));
          chk("pci_stop_with_trdy", 32'(!stop_n), 32'(pe.stop));
          if (pe.chk_rd) begin
            chk("pci_rd_data", ad_out, pe.rd);
            chk("pci_active_rd", 32'(active), 32'd1);
          end
        end
      end else if (!stop_n && stop_prev && trdy_n) begin
        if (pci_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pci_unexpected: got STOP# without data expected none");
        end else begin
          pe = pci_q.pop_front();
          chk("pci_kind_stop", 32'd0, 32'(pe.data));
          chk("tmo_edges", 32'(stb_edges), 32'(pe.edges));
          chk("tmo_stb_drop", 32'(stb), 32'd0);
        end
      end
      if (!devsel_n) devsel_seen = 1'b1;
    end
    stb_prev  = stb;
    stop_prev = stop_n;
  end

  logic [31:0] wdat [0:7];

  // PCI master: address phase, n data phases, honours STOP# and waits for turnaround.
  task automatic master_txn(input logic [3:0] cmd, input logic [31:0] addr, input int n,
                            input logic [3:0] be);
    int   k;
    int   i;
    logic got, sstop, done;
    @(posedge clk); #1;
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = cmd; ad_in = addr;
    @(posedge clk); #1;
    i = 0; done = 1'b0;
    while (!done) begin
      frame_n = (i == n - 1); irdy_n = 1'b0; cbe_n = be; ad_in = wdat[i];
      k = 0; got = 1'b0; sstop = 1'b0;
      while (!got && k < 64) begin
        @(negedge clk);
        if (!trdy_n || !stop_n) begin
          got = 1'b1;
          sstop = !stop_n;
        end
        @(posedge clk); #1;
        k++;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL phase_timeout: got no TRDY#/STOP# expected one within 64 cycles");
        frame_n = 1'b1; irdy_n = 1'b1;
        return;
      end
      if (frame_n) begin
        irdy_n = 1'b1; done = 1'b1;
      end else if (sstop) begin
        frame_n = 1'b1; irdy_n = 1'b0;
        @(negedge clk);
        chk("stop_held", 32'(stop_n), 32'd0);
        @(posedge clk); #1;
        irdy_n = 1'b1; done = 1'b1;
      end else begin
        i++;
      end
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!devsel_n && k < 8);
    chk("devsel_release", 32'(devsel_n), 32'd1);
  endtask

  // Master cycle that must not be claimed.
  task automatic miss_txn(input logic [3:0] cmd, input logic [31:0] addr);
    devsel_seen = 1'b0;
    @(posedge clk); #1;
    frame_n = 1'b0; cbe_n = cmd; ad_in = addr;
    @(posedge clk); #1;
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0;
    repeat (6) @(posedge clk);
    #1 irdy_n = 1'b1;
    @(negedge clk);
    chk("miss_devsel", 32'(devsel_seen), 32'd0);
    chk("miss_stb", 32'(stb), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_devsel", 32'(devsel_n), 32'd1);
    chk("rst_trdy", 32'(trdy_n), 32'd1);
    chk("rst_stop", 32'(stop_n), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_ad_o", ad_out, 32'd0);
    chk("rst_local", {stb, we, adr, sel}, 32'd0);
    chk("rst_dat_o", wdat_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    bar = 20'h000DE;

    // Misses: memory disabled, wrong window, configuration command.
    memen = 1'b0;
    miss_txn(PCI_MEMREAD, 32'h000DE000);
    memen = 1'b1;
    miss_txn(PCI_MEMREAD, 32'h000DF000);
    miss_txn(PCI_CFGREAD, 32'h000DE000);

    // Single write, ack in the first strobe cycle.
    ack_dly = 0;
    wdat[0] = 32'hCAFEF00D;
    loc_q.push_back('{1'b1, 10'h004, 4'hF, 32'hCAFEF00D});
    pci_q.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 0});
    master_txn(PCI_MEMWRITE, 32'h000DE010, 1, 4'h0);
    chk("wr_trdy_after", 32'(trdy_n), 32'd1);
    chk("wr_active_after", 32'(active), 32'd0);

    // Single read, ack one cycle late, fixed data.
    rd_pat = 1'b0; rd_base = 32'h12345678; ack_dly = 1;
    loc_q.push_back('{1'b0, 10'h004, 4'hF, 32'h0});
    pci_q.push_back('{1'b1, 32'h12345678, 1'b1, 1'b0, 0});
    master_txn(PCI_MEMREAD, 32'h000DE010, 1, 4'h0);
    chk("rd_active_after", 32'(active), 32'd0);

    // Four-word read burst.
    rd_pat = 1'b1; ack_dly = 0;
    for (int i = 0; i < 4; i++) begin
      loc_q.push_back('{1'b0, 10'(i), 4'hF, 32'h0});
      pci_q.push_back('{1'b1, 32'hA5A50000 | 32'(i), 1'b1, 1'b0, 0});
    end
    master_txn(PCI_MEMRDMULT, 32'h000DE000, 4, 4'h0);

    // Write burst across the window end: disconnect on 0x3FF.
    wdat[0] = 32'h11111111; wdat[1] = 32'h22222222;
    wdat[2] = 32'h33333333; wdat[3] = 32'h44444444;
    loc_q.push_back('{1'b1, 10'h3FE, 4'hF, 32'h11111111});
    loc_q.push_back('{1'b1, 10'h3FF, 4'hF, 32'h22222222});
    pci_q.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 0});
    pci_q.push_back('{1'b1, 32'h0, 1'b0, 1'b1, 0});
    master_txn(PCI_MEMWRITE, 32'h000DEFF8, 4, 4'h0);

    // Local bus never answers: retry 16 edges after the strobe rises.
    ack_dly = 1000;
    loc_q.push_back('{1'b0, 10'h000, 4'hF, 32'h0});
    pci_q.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 16});
    master_txn(PCI_MEMREAD, 32'h000DE000, 2, 4'h0);

    // Ack on the expiry edge still counts as success.
    ack_dly = 15;
    loc_q.push_back('{1'b0, 10'h001, 4'hF, 32'h0});
    pci_q.push_back('{1'b1, 32'hA5A50001, 1'b1, 1'b0, 0});
    master_txn(PCI_MEMREAD, 32'h000DE004, 1, 4'h0);

    // Unaligned start: first phase performed with STOP#, byte selects inverted.
    ack_dly = 0;
    wdat[0] = 32'hDEADBEEF; wdat[1] = 32'h55555555;
    loc_q.push_back('{1'b1, 10'h008, 4'h5, 32'hDEADBEEF});
    pci_q.push_back('{1'b1, 32'h0, 1'b0, 1'b1, 0});
    master_txn(PCI_MEMWRITE, 32'h000DE021, 2, 4'hA);

    // Reset in the middle of a read that is waiting for the local bus.
    ack_dly = 1000;
    loc_q.push_back('{1'b0, 10'h010, 4'hF, 32'h0});
    @(posedge clk); #1;
    frame_n = 1'b0; cbe_n = PCI_MEMREAD; ad_in = 32'h000DE040;
    @(posedge clk); #1;
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stb", 32'(stb), 32'd0);
    chk("mid_rst_devsel", 32'(devsel_n), 32'd1);
    chk("mid_rst_active", 32'(active), 32'd0);
    irdy_n = 1'b1;
    repeat (20) @(posedge clk);

    @(negedge clk);
    chk("loc_q_empty", 32'(loc_q.size()), 32'd0);
    chk("pci_q_empty", 32'(pci_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_memtarget.md
Name: pci_memtarget

Overview:
- PCI memory-space target that sits directly downstream of cfgspace.
- Consumes cfgspace's memen/base-address outputs and claims memory read/write cycles that hit the configured 4 KB window.
- Bridges each data phase to a simple local req/ack bus that feeds the frame-buffer memory.
- Supports linear bursts, target wait states, disconnect at the 4 KB boundary and a local-latency timeout.

Parameters:
- TIMEOUT, 16: maximum cycles mem_stb_o may wait for mem_ack_i before the target signals STOP#.
- TCW, 5: timeout counter width; must satisfy 2^TCW > TIMEOUT.

Ports:
- pci_clk_i  in  1  PCI clock; single clock domain.
- pci_rst_i  in  1  synchronous reset, active-high.
- pci_frame_ni  in  1  FRAME#.
- pci_irdy_ni  in  1  IRDY#.
- pci_devsel_no  out  1  DEVSEL#.
- pci_trdy_no  out  1  TRDY#.
- pci_stop_no  out  1  STOP#.
- pci_cbe_ni  in  4  C/BE#: command in the address phase, byte enables in data phases.
- pci_ad_i  in  32  AD input.
- pci_ad_o  out  32  read data to the AD mux.
- active_o  out  1  this block owns the AD output mux/tri-states.
- memen_i  in  1  from cfgspace memen_o.
- addr_i  in  20  from cfgspace addr_o; base address AD[31:12].
- mem_stb_o  out  1  local request.
- mem_we_o  out  1  1 = write.
- mem_adr_o  out  10  local word address (AD[11:2]).
- mem_sel_o  out  4  active-high byte selects (~C/BE#).
- mem_dat_o  out  32  write data.
- mem_dat_i  in  32  read data.
- mem_ack_i  in  1  local acknowledge; valid only while mem_stb_o = 1.

Behaviour:
- Reset values: devsel/trdy/stop_no = 1, active_o = 0, pci_ad_o = 0, mem_stb_o = 0, mem_we_o = 0, mem_adr_o = 0, mem_sel_o = 0, mem_dat_o = 0. State = IDLE.
- A reset asserted mid-transaction forces these values at the next edge; no local cycle completes afterwards.
- Claim: in IDLE, at an edge where frame_n = 0 (previous cycle frame_n = 1), the address phase hits when all of the following hold:
  - memen_i = 1;
  - ad_i[31:12] = addr_i;
  - cbe_n is one of 0110 MemRead, 1100 MemReadMultiple, 1110 MemReadLine, 0111 MemWrite, 1111 MemWriteInvalidate.
- On a hit: latch the word address ad_i[11:2] and the direction, and assert devsel_no = 0 after that edge (fast decode). A miss leaves every output idle; config commands are never claimed.
- If ad_i[1:0] ≠ 00, the first data phase is performed and then disconnected: STOP# is asserted with TRDY#.
- States: IDLE, RD_REQ, WR_WAIT, WR_REQ, DATA, STOP, TURN.
- RD_REQ:
  - mem_stb_o = 1, mem_we_o = 0, mem_sel_o = F.
  - Entered after the address edge; active_o = 1 from the following edge (turnaround honoured).
  - On mem_ack_i: pci_ad_o ← mem_dat_i, stb ← 0, trdy_no ← 0, go to DATA.
- WR_WAIT: wait for irdy_n = 0, then latch mem_dat_o ← ad_i and mem_sel_o ← ~cbe_n; stb ← 1, we ← 1, go to WR_REQ.
- WR_REQ: on mem_ack_i, stb ← 0, trdy_no ← 0, go to DATA. Earliest latency from irdy sampled to TRDY# is 2 edges.
- DATA: the phase completes at an edge with irdy_n = 0 and trdy_no = 0. At completion trdy_no ← 1.
  - frame_n = 1 at completion → TURN.
  - frame_n = 0 → word address +1; next state RD_REQ (read) or WR_WAIT (write).
- Boundary disconnect: when the phase being transferred has word address 0x3FF, stop_no is asserted together with trdy_no. No wrap to 0x000 ever reaches the local bus. After completion go to STOP.
- Timeout:
  - The counter resets on each stb rising edge and counts edges with stb = 1 and ack = 0.
  - On reaching TIMEOUT: stb ← 0, stop_no ← 0 with trdy_no = 1. This is a retry if it is the first phase, otherwise a disconnect without data. Go to STOP.
  - A late ack is ignored.
- STOP: hold stop_no = 0 and devsel_no = 0 until frame_n is sampled 1; if irdy_n = 1 at the same edge, go to TURN.
- TURN (one cycle): devsel, trdy and stop_no ← 1 and active_o ← 0 at entry; IDLE next edge.
- Simultaneous events:
  - An ack on the same edge as timeout expiry counts as a success.
  - frame_n = 1 and word 0x3FF at the same completion → TURN (no STOP state).

Decomposition:
- Shared include pci_defs.v: PCI command codes (`PCI_MEMREAD, `PCI_MEMWRITE, `PCI_MEMRDMULT, `PCI_MEMRDLINE, `PCI_MEMWRINV, plus the existing CFG codes) and state encodings.
- Natural sub-module pci_tmo_counter: the timeout counter with start/clear/expire ports.

Test Plan:
- Reset, then memen_i = 0, MemRead at 0x000DE000; also memen_i = 1, MemRead at 0x000DF000 → devsel_no stays 1, mem_stb_o stays 0.
- memen_i = 1, addr_i = 0x000DE, MemWrite to 0x000DE010, data 0xCAFEF00D, cbe 0000, ack one cycle after stb → mem_adr_o = 0x004, mem_sel_o = F, mem_we_o = 1; TRDY# low one cycle; TURN, then IDLE.
- MemRead 0x000DE010, mem_dat_i = 0x12345678, ack 2 cycles after stb → pci_ad_o = 0x12345678 with TRDY# low, active_o = 1 during the transfer and 0 after TURN.
- 4-word MemReadMultiple from 0x000DE000 with irdy held low → mem_adr_o 0, 1, 2, 3; exactly 4 completions; FRAME# high on the 4th → TURN.
- 4-word MemWrite from 0x000DEFF8 → local writes at 0x3FE and 0x3FF only; STOP# with TRDY# on 0x3FF; no write at 0x000.
- MemRead with mem_ack_i held 0 → STOP# low, TRDY# high 16 edges after stb rises; stb drops; STOP# held until FRAME# high; then TURN.
